// File: rtl/tdc_cfg_seq.sv
// tdc_cfg_seq: writes a shadow table of TDC configuration registers over a CSN/WRN bus.
// Optional macro TDC_CFG_AUTOSTART_EN: run one sequence automatically after reset release.
module tdc_cfg_seq #(
    parameter int NUM_REGS  = 7,
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 28,
    parameter int NUM_STOP  = 4,
    parameter int SETUP_CYC = 1,
    parameter int WR_CYC    = 2,
    parameter logic [NUM_REGS*DATA_W-1:0] INIT_TABLE = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_idx,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic              CSN,
    output logic              WRN,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              flag,
    output logic [NUM_STOP-1:0] StopDis
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP, DONE} state_t;
    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_idx;
    logic                r_csn;
    logic                r_wrn;
    logic                r_busy;
    logic                r_flag;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [NUM_STOP-1:0] r_stop;
    logic [DATA_W-1:0]   r_tbl [NUM_REGS];
    logic                w_start;
    logic                w_accept;
    logic                w_tbl_we;
    logic [ADDR_W-1:0]   w_ridx;
    logic [DATA_W-1:0]   w_rd;

`ifdef TDC_CFG_AUTOSTART_EN
    logic [1:0] r_auto;
    // one-shot pulse in the second cycle after reset release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_auto <= 2'b00;
        else          r_auto <= {r_auto[0], 1'b1};
    end
    assign w_start = start | (r_auto == 2'b01);
`else
    assign w_start = start;
`endif

    assign w_accept = w_start && (r_state == IDLE || r_state == DONE);
    assign w_tbl_we = cfg_we && !r_busy && (32'(cfg_idx) < NUM_REGS);
    assign w_ridx   = (r_state == GAP) ? r_idx + ADDR_W'(1) : '0;

    // table read for the next register, bypassing a same-cycle write when starting
    always_comb begin
        w_rd = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (w_ridx == ADDR_W'(i)) w_rd = r_tbl[i];
        if (w_accept && cfg_we && cfg_idx == '0) w_rd = cfg_wdata;
    end

    // shadow table: writable only while no sequence runs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_tbl[i] <= INIT_TABLE[i*DATA_W +: DATA_W];
        end else if (w_tbl_we) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (cfg_idx == ADDR_W'(i)) r_tbl[i] <= cfg_wdata;
        end
    end

    // write sequencer with registered bus outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_csn   <= 1'b1;
            r_wrn   <= 1'b1;
            r_addr  <= '0;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_flag  <= 1'b0;
            r_stop  <= '1;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_state <= SETUP;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_csn   <= 1'b0;
                        r_wrn   <= 1'b1;
                        r_addr  <= '0;
                        r_data  <= w_rd;
                        r_busy  <= 1'b1;
                        r_flag  <= 1'b0;
                        r_stop  <= '1;
                    end
                end
                SETUP: begin
                    if (r_cnt == 4'(SETUP_CYC - 1)) begin
                        r_state <= STROBE;
                        r_cnt   <= '0;
                        r_wrn   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                STROBE: begin
                    if (r_cnt == 4'(WR_CYC - 1)) begin
                        r_state <= HOLD;
                        r_wrn   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                HOLD: begin
                    r_state <= GAP;
                    r_csn   <= 1'b1;
                end
                GAP: begin
                    if (r_idx == ADDR_W'(NUM_REGS - 1)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_flag  <= 1'b1;
                        r_stop  <= '0;
                    end else begin
                        r_state <= SETUP;
                        r_cnt   <= '0;
                        r_idx   <= w_ridx;
                        r_csn   <= 1'b0;
                        r_addr  <= w_ridx;
                        r_data  <= w_rd;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign CSN     = r_csn;
    assign WRN     = r_wrn;
    assign addr    = r_addr;
    assign data    = r_data;
    assign busy    = r_busy;
    assign flag    = r_flag;
    assign StopDis = r_stop;
endmodule

// File: tb/tb_tdc_cfg_seq.sv
// tb_tdc_cfg_seq: randomized bench for tdc_cfg_seq against a per-cycle bus trace model.
module tb_tdc_cfg_seq;
    localparam int N  = 7;
    localparam int AW = 4;
    localparam int DW = 28;
    localparam int NS = 4;
    localparam int S  = 1;
    localparam int W  = 2;
    localparam int P  = S + W + 2;
    localparam logic [N*DW-1:0] INIT = {28'hA6A6A66, 28'h5555555, 28'h4C0FFEE, 28'h3BEEF03,
                                        28'h2DEAD02, 28'h1CAFE01, 28'h0F00D00};

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_idx = '0;
    logic [DW-1:0] cfg_wdata = '0;
    logic          CSN, WRN, busy, flag;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [NS-1:0] StopDis;

    logic          start2 = 1'b0;
    logic          cfg_we2 = 1'b0;
    logic [AW-1:0] cfg_idx2 = '0;
    logic [DW-1:0] cfg_wdata2 = '0;
    logic          csn2, wrn2, busy2, flag2;
    logic [AW-1:0] addr2;
    logic [DW-1:0] data2;
    logic [NS-1:0] stop2;

    tdc_cfg_seq #(.NUM_REGS(N), .INIT_TABLE(INIT)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_wdata(cfg_wdata), .CSN(CSN), .WRN(WRN), .addr(addr), .data(data),
        .busy(busy), .flag(flag), .StopDis(StopDis)
    );

    tdc_cfg_seq #(.NUM_REGS(2), .SETUP_CYC(3), .WR_CYC(4)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .cfg_we(cfg_we2), .cfg_idx(cfg_idx2),
        .cfg_wdata(cfg_wdata2), .CSN(csn2), .WRN(wrn2), .addr(addr2), .data(data2),
        .busy(busy2), .flag(flag2), .StopDis(stop2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          csn;
        logic          wrn;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] m_tbl [N];
    logic          m_busy, m_flag, m_wrn;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            n_chk = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_tbl[i] = INIT[i*DW +: DW];
        q.delete();
        m_busy = 1'b0;
        m_flag = 1'b0;
        m_wrn  = 1'b1;
        m_addr = '0;
        m_data = '0;
    endtask

    task automatic check_outputs();
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            m_busy = 1'b1;
        end else begin
            if (m_busy) m_flag = 1'b1;
            m_busy = 1'b0;
            e.csn  = 1'b1;
            e.wrn  = 1'b1;
            e.addr = m_addr;
            e.data = m_data;
        end
        m_addr = e.addr;
        m_data = e.data;
        m_wrn  = e.wrn;
        chk("csn", CSN, e.csn);
        chk("wrn", WRN, e.wrn);
        chk("addr", addr, e.addr);
        chk("data", data, e.data);
        chk("busy", busy, m_busy);
        chk("flag", flag, m_flag);
        chk("stopdis", StopDis, m_flag ? 4'h0 : 4'hF);
        chk("wrn_low_csn_high", !WRN && CSN, 0);
    endtask

    task automatic step(input logic st, input logic we, input logic [AW-1:0] idx, input logic [DW-1:0] wd);
        exp_t e;
        if (!m_busy) begin
            if (we && idx < N) m_tbl[int'(idx)] = wd;
            if (st) begin
                m_flag = 1'b0;
                for (int r = 0; r < N; r++)
                    for (int t = 0; t < P; t++) begin
                        e.csn  = (t == P - 1);
                        e.wrn  = !(t >= S && t < S + W);
                        e.addr = AW'(r);
                        e.data = m_tbl[r];
                        q.push_back(e);
                    end
            end
        end
        start = st;
        cfg_we = we;
        cfg_idx = idx;
        cfg_wdata = wd;
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  busy_cnt, wrn_cnt, a3_cnt, wl2;
        bit  found;
        model_reset();
        #7;
        chk("rst_csn", CSN, 1);
        chk("rst_wrn", WRN, 1);
        chk("rst_addr", addr, 0);
        chk("rst_data", data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flag", flag, 0);
        chk("rst_stopdis", StopDis, 4'hF);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) step(0, 0, '0, '0);

        busy_cnt = 0;
        wrn_cnt = 0;
        step(1, 0, '0, '0);
        for (int c = 0; c < N * P + 4; c++) begin
            busy_cnt += int'(busy);
            wrn_cnt += int'(!WRN);
            step(0, 0, '0, '0);
        end
        chk("busy_cycles", busy_cnt, N * P);
        chk("wrn_low_cycles", wrn_cnt, N * W);
        chk("done_flag", flag, 1);

        step(0, 1, 4'd3, 28'h1234567);
        step(1, 0, '0, '0);
        a3_cnt = 0;
        for (int c = 0; c < N * P + 2; c++) begin
            if (!CSN && addr == 4'd3) begin
                chk("addr3_data", data, 28'h1234567);
                a3_cnt++;
            end
            step(0, 0, '0, '0);
        end
        chk("addr3_window", a3_cnt, P - 1);

        step(1, 1, 4'd0, 28'hABCDEF1);
        repeat (N * P + 2) step(0, 0, '0, '0);
        step(1, 1, 4'd5, 28'h0BADF00);
        repeat (N * P + 2) step(0, 0, '0, '0);

        busy_cnt = 0;
        step(1, 0, '0, '0);
        repeat (N * P) begin
            busy_cnt += int'(busy);
            step(1, 1, 4'd2, 28'hFFFFFFF);
        end
        repeat (4) step(0, 0, '0, '0);
        chk("busy_cycles_restart", busy_cnt, N * P);

        start2 = 1'b1;
        step(0, 0, '0, '0);
        start2 = 1'b0;
        wl2 = 0;
        for (int c = 0; c < 18; c++) begin
            chk("d2_csn", csn2, (c % 9) == 8);
            chk("d2_wrn", wrn2, !((c % 9) >= 3 && (c % 9) < 7));
            chk("d2_busy", busy2, 1);
            if ((c % 9) < 8) chk("d2_addr", addr2, c / 9);
            chk("d2_wrn_low_csn_high", !wrn2 && csn2, 0);
            wl2 += int'(!wrn2);
            step(0, 0, '0, '0);
        end
        chk("d2_wrn_low_cycles", wl2, 8);
        chk("d2_flag", flag2, 1);
        chk("d2_busy_done", busy2, 0);
        chk("d2_stopdis", stop2, 4'h0);

        repeat (800)
            step($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                 AW'($urandom_range(0, 9)), DW'($urandom()));
        repeat (N * P + 2) step(0, 0, '0, '0);

        found = 1'b0;
        step(1, 1, 4'd4, 28'h4444444);
        for (int c = 0; c < N * P && !found; c++) begin
            if (m_busy && m_addr == 4'd4 && !m_wrn) found = 1'b1;
            else step(0, 0, '0, '0);
        end
        chk("reach_addr4_strobe", found, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_csn", CSN, 1);
        chk("mid_rst_wrn", WRN, 1);
        chk("mid_rst_stopdis", StopDis, 4'hF);
        chk("mid_rst_flag", flag, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", addr, 0);
        model_reset();
        start = 1'b0;
        cfg_we = 1'b0;
        #1 reset_n = 1'b1;
        step(0, 0, '0, '0);
        step(1, 0, '0, '0);
        repeat (N * P + 3) step(0, 0, '0, '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
